// File: rtl/reservation_station.sv
// Reservation station: holds renamed ops until both operands are ready, snoops the CDB,
// dispatches the lowest-index ready entry. Optional macro RS_CDB_BYPASS_EN adds same-cycle CDB-to-issue forwarding.

module rs_entry #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              alloc_we,
  input  logic [OP_W-1:0]   alloc_op,
  input  logic [TAG_W-1:0]  alloc_rs_tag,
  input  logic              alloc_rs_ready,
  input  logic [DATA_W-1:0] alloc_rs_val,
  input  logic [TAG_W-1:0]  alloc_rt_tag,
  input  logic              alloc_rt_ready,
  input  logic [DATA_W-1:0] alloc_rt_val,
  input  logic [TAG_W-1:0]  alloc_dest_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              disp_clr,
  output logic              valid,
  output logic              eligible,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [TAG_W-1:0]  dest_tag
);
  logic              valid_q, valid_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]  rs_tag_q, rs_tag_d, rt_tag_q, rt_tag_d, dest_q, dest_d;
  logic              rs_rdy_q, rs_rdy_d, rt_rdy_q, rt_rdy_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d;
  logic              rs_wake, rt_wake, in_rs_hit, in_rt_hit;

  assign rs_wake   = cdb_valid && !rs_rdy_q && (cdb_tag == rs_tag_q);
  assign rt_wake   = cdb_valid && !rt_rdy_q && (cdb_tag == rt_tag_q);
  assign in_rs_hit = cdb_valid && !alloc_rs_ready && (cdb_tag == alloc_rs_tag);
  assign in_rt_hit = cdb_valid && !alloc_rt_ready && (cdb_tag == alloc_rt_tag);

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    rs_tag_d = rs_tag_q;
    rt_tag_d = rt_tag_q;
    dest_d   = dest_q;
    rs_rdy_d = rs_rdy_q;
    rt_rdy_d = rt_rdy_q;
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;
    if (alloc_we) begin
      valid_d  = 1'b1;
      op_d     = alloc_op;
      rs_tag_d = alloc_rs_tag;
      rt_tag_d = alloc_rt_tag;
      dest_d   = alloc_dest_tag;
      rs_rdy_d = alloc_rs_ready || in_rs_hit;
      rt_rdy_d = alloc_rt_ready || in_rt_hit;
      rs_val_d = in_rs_hit ? cdb_value : alloc_rs_val;
      rt_val_d = in_rt_hit ? cdb_value : alloc_rt_val;
    end else begin
      if (rs_wake) begin
        rs_rdy_d = 1'b1;
        rs_val_d = cdb_value;
      end
      if (rt_wake) begin
        rt_rdy_d = 1'b1;
        rt_val_d = cdb_value;
      end
      if (disp_clr) valid_d = 1'b0;
    end
    if (clr) valid_d = 1'b0;
  end

  // Only occupancy is reset; payload flops are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
    op_q     <= op_d;
    rs_tag_q <= rs_tag_d;
    rt_tag_q <= rt_tag_d;
    dest_q   <= dest_d;
    rs_rdy_q <= rs_rdy_d;
    rt_rdy_q <= rt_rdy_d;
    rs_val_q <= rs_val_d;
    rt_val_q <= rt_val_d;
  end

  assign valid    = valid_q;
  assign op       = op_q;
  assign dest_tag = dest_q;
`ifdef RS_CDB_BYPASS_EN
  assign eligible = valid_q && (rs_rdy_q || rs_wake) && (rt_rdy_q || rt_wake);
  assign a        = rs_rdy_q ? rs_val_q : cdb_value;
  assign b        = rt_rdy_q ? rt_val_q : cdb_value;
`else
  assign eligible = valid_q && rs_rdy_q && rt_rdy_q;
  assign a        = rs_val_q;
  assign b        = rt_val_q;
`endif
endmodule

module reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [OP_W-1:0]   alloc_op,
  input  logic [TAG_W-1:0]  alloc_rs_tag,
  input  logic [TAG_W-1:0]  alloc_rt_tag,
  input  logic              alloc_rs_ready,
  input  logic              alloc_rt_ready,
  input  logic [DATA_W-1:0] alloc_rs_val,
  input  logic [DATA_W-1:0] alloc_rt_val,
  input  logic [TAG_W-1:0]  alloc_dest_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [OP_W-1:0]   issue_op,
  output logic [DATA_W-1:0] issue_a,
  output logic [DATA_W-1:0] issue_b,
  output logic [TAG_W-1:0]  issue_dest_tag,
  output logic [CW-1:0]     count
);
  logic [DEPTH-1:0]             ent_vld, ent_elig, ent_we, ent_clr;
  logic [DEPTH-1:0][OP_W-1:0]   ent_op;
  logic [DEPTH-1:0][DATA_W-1:0] ent_a, ent_b;
  logic [DEPTH-1:0][TAG_W-1:0]  ent_dest;
  logic [IW-1:0]                free_idx, sel_idx;
  logic                         any_elig, alloc_fire, disp_fire;
  logic [CW-1:0]                count_q, count_d;

  // Downward scans so the lowest index wins.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    any_elig = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_vld[i]) free_idx = IW'(i);
      if (ent_elig[i]) begin
        sel_idx  = IW'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign alloc_ready = (count_q < CW'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_valid = any_elig;
  assign disp_fire   = issue_valid && issue_ready;

  always_comb begin
    ent_we  = '0;
    ent_clr = '0;
    if (alloc_fire) ent_we[free_idx] = 1'b1;
    if (disp_fire)  ent_clr[sel_idx] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) u_ent (
      .clk, .rst_n,
      .clr            (flush),
      .alloc_we       (ent_we[g]),
      .alloc_op, .alloc_rs_tag, .alloc_rs_ready, .alloc_rs_val,
      .alloc_rt_tag, .alloc_rt_ready, .alloc_rt_val, .alloc_dest_tag,
      .cdb_valid, .cdb_tag, .cdb_value,
      .disp_clr       (ent_clr[g]),
      .valid          (ent_vld[g]),
      .eligible       (ent_elig[g]),
      .op             (ent_op[g]),
      .a              (ent_a[g]),
      .b              (ent_b[g]),
      .dest_tag       (ent_dest[g])
    );
  end

  assign issue_op       = ent_op[sel_idx];
  assign issue_a        = ent_a[sel_idx];
  assign issue_b        = ent_b[sel_idx];
  assign issue_dest_tag = ent_dest[sel_idx];

  always_comb begin
    count_d = count_q + CW'(alloc_fire) - CW'(disp_fire);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule
